// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared constants, FSM encodings and buffer entry type for the
//               instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    localparam logic [31:0] DEF_RESET_PC  = 32'h1c00_0000;
    localparam logic [5:0]  ECODE_ADEF    = 6'h08;
    localparam logic [8:0]  ESUBCODE_ADEF = 9'h000;

    localparam int          ST_W    = 2;
    localparam logic [1:0]  ST_REQ  = 2'd0;
    localparam logic [1:0]  ST_WAIT = 2'd1;
    localparam logic [1:0]  ST_ERR  = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        has_exc;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
    } fetch_entry_t;

    // Exception commit outranks ertn, which outranks a branch from ID.
    function automatic logic [31:0] sel_redirect(
        input logic        ex_flush,
        input logic [31:0] ex_entry,
        input logic        ertn_flush,
        input logic [31:0] ertn_entry,
        input logic [31:0] br_target
    );
        if (ex_flush)
            return ex_entry;
        else if (ertn_flush)
            return ertn_entry;
        else
            return br_target;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buf
// Description : One-entry output buffer between fetch and decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buf
    import fetch_stage_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic         ready_i,
    input  fetch_entry_t entry_i,
    output logic         valid_o,
    output fetch_entry_t entry_o
);

    logic         valid_q, valid_d;
    fetch_entry_t entry_q, entry_d;

    // Clear wins over load; the producer only loads when the slot is free.
    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            entry_d = entry_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign valid_o = valid_q;
    assign entry_o = entry_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch over a req/addr_ok/data_ok memory port with
//               redirect handling, in-flight cancellation and ADEF detection.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic        ex_flush,
    input  logic [31:0] ex_entry,
    input  logic        ertn_flush,
    input  logic [31:0] ertn_entry,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        has_exception_out,
    output logic [5:0]  ecode_out,
    output logic [8:0]  esubcode_out
);

    logic [ST_W-1:0] state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic            discard_q, discard_d;

    logic            redirect;
    logic [31:0]     redirect_pc;
    logic            pc_aligned;
    logic            has_space;
    logic            accepted;
    logic            buf_valid;
    logic            buf_load;
    fetch_entry_t    buf_in;
    fetch_entry_t    buf_out;

    assign redirect    = ex_flush | ertn_flush | br_taken;
    assign redirect_pc = sel_redirect(ex_flush, ex_entry, ertn_flush, ertn_entry, br_target);
    assign pc_aligned  = (fetch_pc_q[1:0] == 2'b00);
    assign has_space   = !buf_valid || out_ready;
    assign accepted    = inst_sram_req && inst_sram_addr_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        case (state_q)
            ST_REQ: begin
                if (accepted) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = ST_WAIT;
                end else if (has_space && !pc_aligned) begin
                    state_d = ST_ERR;
                end
            end
            ST_WAIT: begin
                if (inst_sram_data_ok) begin
                    discard_d = 1'b0;
                    state_d   = ST_REQ;
                end
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_REQ;
        endcase

        // A request still in flight after the redirect must have its data dropped.
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            case (state_q)
                ST_REQ: begin
                    discard_d = accepted;
                    state_d   = accepted ? ST_WAIT : ST_REQ;
                end
                ST_WAIT: begin
                    discard_d = !inst_sram_data_ok;
                    state_d   = inst_sram_data_ok ? ST_REQ : ST_WAIT;
                end
                default: begin
                    discard_d = 1'b0;
                    state_d   = ST_REQ;
                end
            endcase
        end
    end

    always_comb begin
        inst_sram_req = 1'b0;
        buf_load      = 1'b0;
        buf_in        = '0;
        case (state_q)
            ST_REQ: begin
                if (has_space && !reset) begin
                    if (pc_aligned) begin
                        inst_sram_req = 1'b1;
                    end else begin
                        buf_load        = 1'b1;
                        buf_in.pc       = fetch_pc_q;
                        buf_in.has_exc  = 1'b1;
                        buf_in.ecode    = ECODE_ADEF;
                        buf_in.esubcode = ESUBCODE_ADEF;
                    end
                end
            end
            ST_WAIT: begin
                if (inst_sram_data_ok && !discard_q) begin
                    buf_load    = 1'b1;
                    buf_in.pc   = fetch_pc_q - 32'd4;
                    buf_in.inst = inst_sram_rdata;
                end
            end
            default: ;
        endcase
        if (redirect)
            buf_load = 1'b0;
        inst_sram_addr = inst_sram_req ? fetch_pc_q : 32'h0;
    end

    fetch_buf u_buf (
        .clk     (clk),
        .reset   (reset),
        .load_i  (buf_load),
        .clear_i (redirect),
        .ready_i (out_ready),
        .entry_i (buf_in),
        .valid_o (buf_valid),
        .entry_o (buf_out)
    );

    assign out_valid         = buf_valid;
    assign pc_out            = buf_out.pc;
    assign inst_out          = buf_out.inst;
    assign has_exception_out = buf_out.has_exc;
    assign ecode_out         = buf_out.ecode;
    assign esubcode_out      = buf_out.esubcode;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage with a variable-latency
//               memory responder and an in-order fetch-stream scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        ex_flush = 1'b0, ertn_flush = 1'b0, br_taken = 1'b0;
    logic [31:0] ex_entry = '0, ertn_entry = '0, br_target = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] pc_out, inst_out;
    logic        has_exception_out;
    logic [5:0]  ecode_out;
    logic [8:0]  esubcode_out;

    int tests = 0;
    int fails = 0;

    // memory responder knobs
    int          ack_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          force_en = 1'b0;
    logic [31:0] force_val = '0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RPC)) dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (addr_ok),
        .inst_sram_data_ok (data_ok),
        .inst_sram_rdata   (rdata),
        .ex_flush          (ex_flush),
        .ex_entry          (ex_entry),
        .ertn_flush        (ertn_flush),
        .ertn_entry        (ertn_entry),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .pc_out            (pc_out),
        .inst_out          (inst_out),
        .has_exception_out (has_exception_out),
        .ecode_out         (ecode_out),
        .esubcode_out      (esubcode_out)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == RPC)
            return 32'h02800c0c;
        return (a * 32'h9e3779b1) ^ 32'h13572468;
    endfunction

    // Memory: one outstanding request, data returned lat cycles after accept.
    initial begin : g_mem
        bit          pend;
        int          lat_cnt;
        logic [31:0] pend_data;
        pend = 1'b0; lat_cnt = 0; pend_data = '0;
        addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
        forever begin
            @(posedge clk); #2;
            data_ok = !reset && pend && (lat_cnt == 0);
            rdata   = data_ok ? pend_data : 32'h0;
            addr_ok = !reset && !pend && inst_sram_req && (int'($urandom_range(0, 99)) < ack_pct);
            @(negedge clk);
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (data_ok) pend = 1'b0;
                else if (pend) lat_cnt--;
                if (inst_sram_req && addr_ok) begin
                    pend      = 1'b1;
                    lat_cnt   = int'($urandom_range(lat_min, lat_max)) - 1;
                    pend_data = force_en ? force_val : memf(inst_sram_addr);
                end
            end
        end
    end

    initial begin : g_watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_redirects();
        ex_flush = 1'b0; ertn_flush = 1'b0; br_taken = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_redirects();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (out_valid) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        tests++;
        if (inst_sram_req !== 1'b0 || inst_sram_addr !== 32'h0) begin
            fails++;
            $display("FAIL reset_req: req=%b addr=%h expected 0/0", inst_sram_req, inst_sram_addr);
        end
        tests++;
        if (out_valid !== 1'b0 || pc_out !== 32'h0 || inst_out !== 32'h0) begin
            fails++;
            $display("FAIL reset_out: valid=%b pc=%h inst=%h expected all 0", out_valid, pc_out, inst_out);
        end
        tests++;
        if (has_exception_out !== 1'b0 || ecode_out !== 6'h0 || esubcode_out !== 9'h0) begin
            fails++;
            $display("FAIL reset_exc: exc=%b ecode=%h esub=%h expected all 0",
                     has_exception_out, ecode_out, esubcode_out);
        end
    endtask

    task automatic test_first_fetch();
        int n;
        ack_pct = 100; lat_min = 1; lat_max = 1; out_ready = 1'b1;
        do_reset();
        @(negedge clk);
        tests++;
        if (inst_sram_req !== 1'b1 || inst_sram_addr !== RPC) begin
            fails++;
            $display("FAIL first_req: req=%b addr=%h expected 1/%h", inst_sram_req, inst_sram_addr, RPC);
        end
        // addr_ok in this cycle, data_ok next, out_valid the one after
        wait_valid(10, n);
        tests++;
        if (n !== 1) begin
            fails++;
            $display("FAIL first_latency: cycles=%0d expected 1 after accept cycle", n);
        end
        tests++;
        if (pc_out !== RPC || inst_out !== 32'h02800c0c || has_exception_out !== 1'b0) begin
            fails++;
            $display("FAIL first_data: pc=%h inst=%h exc=%b expected %h/02800c0c/0",
                     pc_out, inst_out, has_exception_out, RPC);
        end
        tests++;
        if (inst_sram_req !== 1'b1 || inst_sram_addr !== RPC + 32'd4) begin
            fails++;
            $display("FAIL next_req: req=%b addr=%h expected 1/%h", inst_sram_req, inst_sram_addr, RPC + 32'd4);
        end
    endtask

    task automatic test_backpressure();
        int          n;
        logic [31:0] h_pc, h_inst;
        bit          bad;
        ack_pct = 100; lat_min = 2; lat_max = 2; out_ready = 1'b0;
        do_reset();
        wait_valid(20, n);
        tests++;
        if (n < 0) begin
            fails++;
            $display("FAIL bp_valid: out_valid never seen, expected within 20 cycles");
        end
        h_pc = pc_out; h_inst = inst_out;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || pc_out !== h_pc || inst_out !== h_inst || inst_sram_req !== 1'b0)
                bad = 1'b1;
        end
        tests++;
        if (bad || h_pc !== RPC) begin
            fails++;
            $display("FAIL bp_hold: pc=%h inst=%h valid=%b req=%b expected pc %h held, req 0",
                     pc_out, inst_out, out_valid, inst_sram_req, RPC);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (inst_sram_req !== 1'b1 || inst_sram_addr !== RPC + 32'd4) begin
            fails++;
            $display("FAIL bp_release: req=%b addr=%h expected 1/%h", inst_sram_req, inst_sram_addr, RPC + 32'd4);
        end
    endtask

    task automatic test_branch_in_wait();
        logic [31:0] first_req, first_pc, first_inst;
        bit          seen_req, seen_out;
        ack_pct = 100; lat_min = 4; lat_max = 4; out_ready = 1'b1;
        force_en = 1'b1; force_val = 32'hdeadbeef;
        do_reset();
        @(negedge clk);
        tick();
        br_taken = 1'b1; br_target = 32'h1c000100; force_en = 1'b0;
        tick();
        clear_redirects();
        seen_req = 1'b0; seen_out = 1'b0;
        first_req = '0; first_pc = '0; first_inst = '0;
        for (int i = 0; i < 20 && !(seen_req && seen_out); i++) begin
            @(negedge clk);
            if (inst_sram_req && !seen_req) begin
                seen_req = 1'b1; first_req = inst_sram_addr;
            end
            if (out_valid && !seen_out) begin
                seen_out = 1'b1; first_pc = pc_out; first_inst = inst_out;
            end
        end
        tests++;
        if (!seen_req || first_req !== 32'h1c000100) begin
            fails++;
            $display("FAIL br_req: seen=%b addr=%h expected 1c000100", seen_req, first_req);
        end
        tests++;
        if (!seen_out || first_pc !== 32'h1c000100 || first_inst !== memf(32'h1c000100)) begin
            fails++;
            $display("FAIL br_discard: seen=%b pc=%h inst=%h expected 1c000100/%h",
                     seen_out, first_pc, first_inst, memf(32'h1c000100));
        end
    endtask

    task automatic test_ex_priority();
        int n;
        ack_pct = 100; lat_min = 2; lat_max = 2; out_ready = 1'b0;
        do_reset();
        wait_valid(20, n);
        tick();
        ex_flush = 1'b1; ex_entry = 32'h1c008000;
        br_taken = 1'b1; br_target = 32'h1c000100;
        tick();
        clear_redirects();
        @(negedge clk);
        tests++;
        if (n < 0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL ex_clear: filled=%0d out_valid=%b expected filled, then 0", n, out_valid);
        end
        tests++;
        if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c008000) begin
            fails++;
            $display("FAIL ex_prio: req=%b addr=%h expected 1/1c008000", inst_sram_req, inst_sram_addr);
        end
    endtask

    task automatic test_misaligned();
        int n;
        bit bad;
        ack_pct = 100; lat_min = 1; lat_max = 1; out_ready = 1'b1;
        do_reset();
        br_taken = 1'b1; br_target = 32'h1c000102;
        tick();
        clear_redirects();
        wait_valid(20, n);
        tests++;
        if (n < 0 || pc_out !== 32'h1c000102 || has_exception_out !== 1'b1 || inst_out !== 32'h0) begin
            fails++;
            $display("FAIL adef_out: seen=%0d pc=%h exc=%b inst=%h expected 1c000102/1/0",
                     n, pc_out, has_exception_out, inst_out);
        end
        tests++;
        if (ecode_out !== 6'h08 || esubcode_out !== 9'h0) begin
            fails++;
            $display("FAIL adef_code: ecode=%h esub=%h expected 08/000", ecode_out, esubcode_out);
        end
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (inst_sram_req !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL adef_stall: req=%b valid=%b expected 0/0 while stalled", inst_sram_req, out_valid);
        end
        tick();
        ertn_flush = 1'b1; ertn_entry = 32'h1c000200;
        tick();
        clear_redirects();
        @(negedge clk);
        tests++;
        if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000200) begin
            fails++;
            $display("FAIL adef_ertn: req=%b addr=%h expected 1/1c000200", inst_sram_req, inst_sram_addr);
        end
    endtask

    task automatic test_reset_in_wait();
        int n;
        ack_pct = 100; lat_min = 5; lat_max = 5; out_ready = 1'b1;
        do_reset();
        @(negedge clk);
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || pc_out !== 32'h0 || inst_out !== 32'h0 || has_exception_out !== 1'b0 ||
            inst_sram_req !== 1'b0 || inst_sram_addr !== 32'h0) begin
            fails++;
            $display("FAIL rst_wait: valid=%b pc=%h inst=%h req=%b addr=%h expected all 0",
                     out_valid, pc_out, inst_out, inst_sram_req, inst_sram_addr);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (inst_sram_req !== 1'b1 || inst_sram_addr !== RPC) begin
            fails++;
            $display("FAIL rst_req: req=%b addr=%h expected 1/%h", inst_sram_req, inst_sram_addr, RPC);
        end
        wait_valid(20, n);
        tests++;
        if (n < 0 || pc_out !== RPC || inst_out !== 32'h02800c0c) begin
            fails++;
            $display("FAIL rst_refetch: seen=%0d pc=%h inst=%h expected %h/02800c0c", n, pc_out, inst_out, RPC);
        end
    endtask

    function automatic logic [31:0] rnd_target();
        logic [31:0] t;
        t = RPC + (32'($urandom_range(0, 1023)) << 2);
        if ($urandom_range(0, 9) == 0) t = t + 32'd2;
        return t;
    endfunction

    // Scoreboard: deliveries form the sequence tgt, tgt+4, ... from the last
    // redirect; a misaligned start yields exactly one ADEF entry and then silence.
    task automatic test_random();
        logic [31:0] exp_pc, h_pc, h_inst;
        bit          err_done, hold_v, h_exc, redir;
        int          deliveries;
        ack_pct = 60; lat_min = 1; lat_max = 4; out_ready = 1'b1;
        do_reset();
        exp_pc = RPC; err_done = 1'b0; hold_v = 1'b0; deliveries = 0;
        h_pc = '0; h_inst = '0; h_exc = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc != 0) tick();
            out_ready = ($urandom_range(0, 99) < 70);
            clear_redirects();
            if ($urandom_range(0, 99) < 4) begin
                ex_flush   = $urandom_range(0, 2) == 0;
                ertn_flush = $urandom_range(0, 2) == 0;
                br_taken   = !(ex_flush || ertn_flush) || ($urandom_range(0, 1) == 0);
                ex_entry   = rnd_target();
                ertn_entry = rnd_target();
                br_target  = rnd_target();
            end
            redir = ex_flush || ertn_flush || br_taken;
            @(negedge clk);
            if (hold_v) begin
                tests++;
                if (out_valid !== 1'b1 || pc_out !== h_pc || inst_out !== h_inst || has_exception_out !== h_exc) begin
                    fails++;
                    $display("FAIL rnd_hold: valid=%b pc=%h inst=%h expected 1/%h/%h", out_valid, pc_out, inst_out, h_pc, h_inst);
                end
            end
            hold_v = out_valid && !out_ready && !redir;
            h_pc = pc_out; h_inst = inst_out; h_exc = has_exception_out;
            if (exp_pc[1:0] != 2'b00) begin
                tests++;
                if (inst_sram_req !== 1'b0) begin
                    fails++;
                    $display("FAIL rnd_err_req: req=%b addr=%h expected 0 (fetch pc %h misaligned)", inst_sram_req, inst_sram_addr, exp_pc);
                end
            end
            if (out_valid && out_ready) begin
                tests++;
                deliveries++;
                if (exp_pc[1:0] != 2'b00) begin
                    if (err_done || pc_out !== exp_pc || has_exception_out !== 1'b1 || inst_out !== 32'h0 ||
                        ecode_out !== 6'h08 || esubcode_out !== 9'h0) begin
                        fails++;
                        $display("FAIL rnd_adef: pc=%h exc=%b ecode=%h dup=%b expected %h/1/08/0",
                                 pc_out, has_exception_out, ecode_out, err_done, exp_pc);
                    end
                    err_done = 1'b1;
                end else begin
                    if (pc_out !== exp_pc || inst_out !== memf(exp_pc) || has_exception_out !== 1'b0) begin
                        fails++;
                        $display("FAIL rnd_stream: pc=%h inst=%h exc=%b expected %h/%h/0",
                                 pc_out, inst_out, has_exception_out, exp_pc, memf(exp_pc));
                    end
                    exp_pc = exp_pc + 32'd4;
                end
            end
            if (redir) begin
                exp_pc   = ex_flush ? ex_entry : (ertn_flush ? ertn_entry : br_target);
                err_done = 1'b0;
            end
        end
        tick();
        clear_redirects();
        tests++;
        if (deliveries < 100) begin
            fails++;
            $display("FAIL rnd_progress: deliveries=%0d expected at least 100", deliveries);
        end
    endtask

    initial begin : g_main
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_branch_in_wait();
        test_ex_priority();
        test_misaligned();
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
